ram_arbiter_2x8: RTL and testbench

- Two-port round-robin arbiter and sequencer in front of one shared ram_2x8 (2 words x 8 bits).
- Each requester issues a single-word read or write with a req/done handshake.
- The arbiter latches the winning request, drives the RAM for exactly one access cycle, captures read data, then signals completion.
- Sits between two bus masters (e.g. a loader and a consumer) and the RAM instance.

---
 rtl/ram_ctrl_pkg.sv | 16 +
 rtl/ram_arbiter_2x8_if.sv | 48 ++++
 rtl/ram_2x8.sv | 19 +
 rtl/rr_arb2.sv | 13 +
 rtl/ram_arbiter_2x8.sv | 112 +++++++++++
 tb/tb_ram_arbiter_2x8.sv | 203 ++++++++++++++++++++
 6 files changed

// File: rtl/ram_ctrl_pkg.sv
// Shared definitions for the 2x8 RAM arbiter: FSM encoding, access direction codes
// and the default word width.
package ram_ctrl_pkg;

  localparam int DW_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

endpackage

// File: rtl/ram_arbiter_2x8_if.sv
// Requester handshake signals for both ports plus the arbiter-to-RAM bus.
interface ram_arbiter_2x8_if #(
  parameter int DW = 8,
  parameter int CW = 8
);
  logic          req0;
  logic          rw0;
  logic          addr0;
  logic [DW-1:0] wdata0;
  logic          gnt0;
  logic          done0;
  logic [DW-1:0] rdata0;
  logic [CW-1:0] cnt0;

  logic          req1;
  logic          rw1;
  logic          addr1;
  logic [DW-1:0] wdata1;
  logic          gnt1;
  logic          done1;
  logic [DW-1:0] rdata1;
  logic [CW-1:0] cnt1;

  logic          ram_rw;
  logic          ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  // Requester side: both bus masters.
  modport master (
    output req0, rw0, addr0, wdata0, req1, rw1, addr1, wdata1,
    input  gnt0, done0, rdata0, cnt0, gnt1, done1, rdata1, cnt1
  );

  // Arbiter side: serves both requesters and drives the RAM.
  modport slave (
    input  req0, rw0, addr0, wdata0, req1, rw1, addr1, wdata1,
    output gnt0, done0, rdata0, cnt0, gnt1, done1, rdata1, cnt1,
    output ram_rw, ram_addr, ram_wdata,
    input  ram_rdata
  );

  // RAM side.
  modport mem (
    input  ram_rw, ram_addr, ram_wdata,
    output ram_rdata
  );
endinterface

// File: rtl/ram_2x8.sv
// Two-word RAM: synchronous write on the rising edge, combinational read that
// returns zero while a write is being presented.
module ram_2x8 #(
  parameter int DW = 8
) (
  input  logic          CLK_,
  input  logic          R_W_,
  input  logic          ADDR_,
  input  logic [DW-1:0] data_in,
  output logic [DW-1:0] data_out
);
  logic [DW-1:0] mem [2];

  always_ff @(posedge CLK_) begin
    if (R_W_) mem[ADDR_] <= data_in;
  end

  assign data_out = R_W_ ? '0 : mem[ADDR_];
endmodule

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin pick; ptr names the requester favoured on a tie.
module rr_arb2 (
  input  logic req0,
  input  logic req1,
  input  logic ptr,
  output logic winner,
  output logic valid
);
  always_comb begin
    valid  = req0 | req1;
    winner = (req0 & req1) ? ptr : req1;
  end
endmodule

// File: rtl/ram_arbiter_2x8.sv
// Two-port round-robin arbiter/sequencer for a shared 2x8 RAM: one 3-cycle
// IDLE -> ACCESS -> DONE transaction per grant.
module ram_arbiter_2x8
  import ram_ctrl_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int CW = 8
) (
  input  logic                CLK_,
  input  logic                CLR,
  ram_arbiter_2x8_if.slave    bus
);

  state_t        state, state_nxt;
  logic          ptr;
  logic          pick, pick_vld;
  logic          win_id, win_rw, win_addr;
  logic [DW-1:0] win_wdata;
  logic [DW-1:0] rdata0_q, rdata1_q;
  logic [CW-1:0] cnt0_q, cnt1_q;

  rr_arb2 u_arb (
    .req0   (bus.req0),
    .req1   (bus.req1),
    .ptr    (ptr),
    .winner (pick),
    .valid  (pick_vld)
  );

  always_ff @(posedge CLK_ or negedge CLR) begin
    if (!CLR) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (pick_vld) state_nxt = ST_ACCESS;
      ST_ACCESS: state_nxt = ST_DONE;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Request is frozen at the arbitration edge; requester inputs are ignored afterwards.
  always_ff @(posedge CLK_ or negedge CLR) begin
    if (!CLR) begin
      win_id    <= 1'b0;
      win_rw    <= RW_READ;
      win_addr  <= 1'b0;
      win_wdata <= '0;
    end else if (state == ST_IDLE && pick_vld) begin
      win_id    <= pick;
      win_rw    <= pick ? bus.rw1    : bus.rw0;
      win_addr  <= pick ? bus.addr1  : bus.addr0;
      win_wdata <= pick ? bus.wdata1 : bus.wdata0;
    end
  end

  always_ff @(posedge CLK_ or negedge CLR) begin
    if (!CLR)                 ptr <= 1'b0;
    else if (state == ST_DONE) ptr <= ~win_id;
  end

  always_ff @(posedge CLK_ or negedge CLR) begin
    if (!CLR) begin
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else if (state == ST_ACCESS && win_rw == RW_READ) begin
      if (win_id) rdata1_q <= bus.ram_rdata;
      else        rdata0_q <= bus.ram_rdata;
    end
  end

  always_ff @(posedge CLK_ or negedge CLR) begin
    if (!CLR) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else if (state == ST_DONE) begin
      if (win_id) cnt1_q <= cnt1_q + CW'(1);
      else        cnt0_q <= cnt0_q + CW'(1);
    end
  end

  // ram_rw is decoded from state so an asynchronous reset drops it immediately.
  always_comb begin
    bus.gnt0      = 1'b0;
    bus.gnt1      = 1'b0;
    bus.done0     = 1'b0;
    bus.done1     = 1'b0;
    bus.ram_rw    = 1'b0;
    bus.ram_addr  = win_addr;
    bus.ram_wdata = win_wdata;
    if (state == ST_ACCESS || state == ST_DONE) begin
      bus.gnt0 = ~win_id;
      bus.gnt1 = win_id;
    end
    if (state == ST_DONE) begin
      bus.done0 = ~win_id;
      bus.done1 = win_id;
    end
    if (state == ST_ACCESS) bus.ram_rw = win_rw;
  end

  always_comb begin
    bus.rdata0 = rdata0_q;
    bus.rdata1 = rdata1_q;
    bus.cnt0   = cnt0_q;
    bus.cnt1   = cnt1_q;
  end

endmodule

// File: tb/tb_ram_arbiter_2x8.sv
// Directed bench for ram_arbiter_2x8 with a ram_2x8 instance and a queue of
// expected completions built from a small memory/counter model.
module tb_ram_arbiter_2x8;
  import ram_ctrl_pkg::*;

  localparam int DW = 8;
  localparam int CW = 8;

  logic CLK_ = 1'b0;
  logic CLR  = 1'b0;

  ram_arbiter_2x8_if #(.DW(DW), .CW(CW)) bus ();

  ram_arbiter_2x8 #(.DW(DW), .CW(CW)) dut (
    .CLK_ (CLK_),
    .CLR  (CLR),
    .bus  (bus)
  );

  ram_2x8 #(.DW(DW)) u_ram (
    .CLK_     (CLK_),
    .R_W_     (bus.ram_rw),
    .ADDR_    (bus.ram_addr),
    .data_in  (bus.ram_wdata),
    .data_out (bus.ram_rdata)
  );

  always #5 CLK_ = ~CLK_;

  typedef struct {
    int            id;
    logic [DW-1:0] rdata;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] mem_m [2];
  logic [DW-1:0] rd_m  [2];
  logic [CW-1:0] cnt_m [2];
  int            rem   [2];
  int            total = 0;
  int            bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    rd_m[0] = '0;  rd_m[1] = '0;
    cnt_m[0] = '0; cnt_m[1] = '0;
    rem[0] = 0;    rem[1] = 0;
  endtask

  task automatic drop_req(input int id);
    if (id == 0) bus.req0 = 1'b0;
    else         bus.req1 = 1'b0;
  endtask

  task automatic issue(input int id, input logic rw, input logic a, input logic [DW-1:0] wd);
    if (rw == RW_WRITE) mem_m[a] = wd;
    else                rd_m[id] = mem_m[a];
    cnt_m[id] = cnt_m[id] + CW'(1);
    sb.push_back('{id, rd_m[id], cnt_m[id]});
    rem[id]++;
    if (id == 0) begin
      bus.req0 = 1'b1; bus.rw0 = rw; bus.addr0 = a; bus.wdata0 = wd;
    end else begin
      bus.req1 = 1'b1; bus.rw1 = rw; bus.addr1 = a; bus.wdata1 = wd;
    end
  endtask

  // Runs until every queued completion is seen; lat > 0 also checks first grant/done timing.
  task automatic drain(input int lat);
    int   cyc;
    int   pend;
    int   id;
    bit   first;
    exp_t e;
    logic [CW-1:0] pend_cnt;
    cyc = 0; pend = -1; first = 1'b1; pend_cnt = '0;
    while ((sb.size() > 0 || pend >= 0) && cyc < 60) begin
      @(negedge CLK_);
      cyc++;
      chk("gnt_overlap", 32'(bus.gnt0 & bus.gnt1), 32'd0);
      if (pend >= 0) begin
        chk(pend ? "cnt1" : "cnt0", pend ? 32'(bus.cnt1) : 32'(bus.cnt0), 32'(pend_cnt));
        pend = -1;
      end
      if (lat > 0 && first && cyc == 1 && sb.size() > 0)
        chk("gnt_latency", sb[0].id ? 32'(bus.gnt1) : 32'(bus.gnt0), 32'd1);
      if (bus.done0 || bus.done1) begin
        id = bus.done1 ? 1 : 0;
        if (sb.size() == 0) begin
          chk("spurious_done", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("done_id", 32'(id), 32'(e.id));
          chk(id ? "rdata1" : "rdata0", id ? 32'(bus.rdata1) : 32'(bus.rdata0), 32'(e.rdata));
          if (lat > 0 && first) chk("done_latency", 32'(cyc), 32'(lat));
          first    = 1'b0;
          pend     = id;
          pend_cnt = e.cnt;
          rem[id]--;
          if (rem[id] <= 0) drop_req(id);
        end
      end
    end
    if (cyc >= 60) chk("drain_timeout", 32'd0, 32'd1);
    chk("rdata0_final", 32'(bus.rdata0), 32'(rd_m[0]));
    chk("rdata1_final", 32'(bus.rdata1), 32'(rd_m[1]));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_gnt"},   {30'd0, bus.gnt1, bus.gnt0}, 32'd0);
    chk({tag, "_done"},  {30'd0, bus.done1, bus.done0}, 32'd0);
    chk({tag, "_rdata"}, {16'd0, bus.rdata1, bus.rdata0}, 32'd0);
    chk({tag, "_cnt"},   {16'd0, bus.cnt1, bus.cnt0}, 32'd0);
    chk({tag, "_ram"},   {23'd0, bus.ram_rw, bus.ram_addr, bus.ram_wdata}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.req0 = 1'b0; bus.rw0 = 1'b0; bus.addr0 = 1'b0; bus.wdata0 = '0;
    bus.req1 = 1'b0; bus.rw1 = 1'b0; bus.addr1 = 1'b0; bus.wdata1 = '0;
    reset_model();

    // Power-on reset and quiet idle afterwards.
    #1;
    chk_reset_outputs("por");
    @(negedge CLK_); @(negedge CLK_);
    CLR = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK_);
      chk("idle_gnt", {30'd0, bus.gnt1, bus.gnt0}, 32'd0);
    end

    // Requester 0: write then read back.
    issue(0, RW_WRITE, 1'b1, 8'hA5); drain(2);
    issue(0, RW_READ,  1'b1, 8'h00); drain(2);

    // Address isolation across requesters.
    issue(1, RW_WRITE, 1'b0, 8'h3C); drain(2);
    issue(0, RW_WRITE, 1'b1, 8'hC3); drain(2);
    issue(0, RW_READ,  1'b0, 8'h00); drain(2);
    issue(1, RW_READ,  1'b1, 8'h00); drain(2);

    // Mid-run reset clears counters and read registers.
    CLR = 1'b0;
    #1;
    chk_reset_outputs("mid");
    reset_model();
    @(negedge CLK_);
    CLR = 1'b1;

    // Simultaneous requests held high: strict alternation 0,1,0,1.
    issue(0, RW_READ, 1'b0, 8'h00);
    issue(1, RW_READ, 1'b1, 8'h00);
    issue(0, RW_READ, 1'b0, 8'h00);
    issue(1, RW_READ, 1'b1, 8'h00);
    drain(2);

    // req dropped during ACCESS still completes exactly once.
    issue(1, RW_WRITE, 1'b0, 8'h5A);
    @(negedge CLK_);
    chk("drop_gnt1", 32'(bus.gnt1), 32'd1);
    bus.req1 = 1'b0;
    drain(0);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK_);
      chk("drop_no_redone", {30'd0, bus.done1, bus.done0}, 32'd0);
    end

    // Reset during ACCESS of a write must suppress the write.
    issue(0, RW_WRITE, 1'b0, 8'h11); drain(2);
    bus.req0 = 1'b1; bus.rw0 = RW_WRITE; bus.addr0 = 1'b0; bus.wdata0 = 8'hFF;
    @(negedge CLK_);
    chk("abort_gnt0", 32'(bus.gnt0), 32'd1);
    chk("abort_ram_rw_before", 32'(bus.ram_rw), 32'd1);
    CLR = 1'b0;
    #1;
    chk("abort_ram_rw_async", 32'(bus.ram_rw), 32'd0);
    chk_reset_outputs("abort");
    bus.req0 = 1'b0;
    reset_model();
    @(negedge CLK_);
    CLR = 1'b1;
    issue(0, RW_READ, 1'b0, 8'h00); drain(2);
    chk("abort_readback", 32'(bus.rdata0), 32'h11);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
